// File: rtl/bus_hub_if.sv
// bus_hub_if: CPU data-port and slave-side signals of the bus hub.
// The "master" modport is the hub's view. The "slave" modport is the
// environment's view: the CPU and the slaves together.
interface bus_hub_if #(
   parameter int N_SLAVE = 8,
   parameter int AW      = 32,
   parameter int DW      = 32
);
   // CPU side
   logic [AW-1:0]               m_addr;
   logic [DW-1:0]               m_wdata;
   logic                        m_rd;
   logic                        m_we;
   logic [DW-1:0]               m_rdata;
   logic                        m_ready;
   logic                        m_err;
   // slave side; s_rdata lane i is bits [i*DW +: DW]
   logic [N_SLAVE-1:0]          s_sel;
   logic [AW-1:0]               s_addr;
   logic [DW-1:0]               s_wdata;
   logic                        s_rd;
   logic                        s_we;
   logic [N_SLAVE-1:0][DW-1:0]  s_rdata;
   logic [N_SLAVE-1:0]          s_ready;

   modport master (
      input  m_addr, m_wdata, m_rd, m_we, s_rdata, s_ready,
      output m_rdata, m_ready, m_err, s_sel, s_addr, s_wdata, s_rd, s_we
   );

   modport slave (
      output m_addr, m_wdata, m_rd, m_we, s_rdata, s_ready,
      input  m_rdata, m_ready, m_err, s_sel, s_addr, s_wdata, s_rd, s_we
   );
endinterface

// File: rtl/bus_hub.sv
// bus_hub: decodes CPU accesses onto N memory-mapped slaves.
// It waits on the selected slave's ready and aborts a stuck access after
// TIMEOUT wait cycles. Errors are returned with a captured fault address.

// Per-slave address comparator: slave matches when (addr & mask) == base.
module bus_hub_match #(
   parameter int AW = 32
) (
   input  logic [AW-1:0] addr_i,
   input  logic [AW-1:0] base_i,
   input  logic [AW-1:0] mask_i,
   output logic          hit_o
);
   assign hit_o = ((addr_i & mask_i) == base_i);
endmodule

module bus_hub #(
   parameter int                     N_SLAVE    = 8,
   parameter int                     AW         = 32,
   parameter int                     DW         = 32,
   parameter logic [N_SLAVE*AW-1:0]  SLAVE_BASE = '0,
   parameter logic [N_SLAVE*AW-1:0]  SLAVE_MASK = '0,
   parameter int                     TIMEOUT    = 15
) (
   input  logic           clk,
   input  logic           RSTN,
   bus_hub_if.master      bus,
   output logic [AW-1:0]  err_addr,
   output logic [7:0]     err_cnt
);
   // The wait counter holds completed wait edges. A timeout fires on the
   // edge where it already equals TIMEOUT-1.
   localparam int TO_M1 = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam int CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic          rd;
      logic          we;
   } req_t;

   state_t              state_q, state_d;
   logic [N_SLAVE-1:0]  s_sel_q, s_sel_d;
   logic [AW-1:0]       s_addr_q, s_addr_d;
   logic [DW-1:0]       s_wdata_q, s_wdata_d;
   logic                s_rd_q, s_rd_d;
   logic                s_we_q, s_we_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [DW-1:0]       m_rdata_q, m_rdata_d;
   logic                m_ready_q, m_ready_d;
   logic                m_err_q, m_err_d;
   logic [AW-1:0]       err_addr_q, err_addr_d;
   logic [7:0]          err_cnt_q, err_cnt_d;

   req_t                req;
   logic [N_SLAVE-1:0]  hit;
   logic [N_SLAVE-1:0]  hit_1h;
   logic [DW-1:0]       rdata_sel;
   logic                rdy_sel;

   assign req = '{addr: bus.m_addr, wdata: bus.m_wdata, rd: bus.m_rd, we: bus.m_we};

   // One comparator per slave channel.
   for (genvar i = 0; i < N_SLAVE; i++) begin : g_match
      bus_hub_match #(.AW(AW)) u_match (
         .addr_i (req.addr),
         .base_i (SLAVE_BASE[i*AW +: AW]),
         .mask_i (SLAVE_MASK[i*AW +: AW]),
         .hit_o  (hit[i])
      );
   end

   // Keep only the lowest-index hit so overlapping windows resolve by priority.
   assign hit_1h = hit & (~hit + N_SLAVE'(1));

   // Read data and ready of the currently selected slave. s_sel is one-hot or zero.
   always_comb begin
      rdata_sel = '0;
      for (int i = 0; i < N_SLAVE; i++) begin
         if (s_sel_q[i]) rdata_sel = rdata_sel | bus.s_rdata[i];
      end
   end
   assign rdy_sel = |(s_sel_q & bus.s_ready);

   // FSM state register.
   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state, strobes, response and error bookkeeping.
   always_comb begin
      state_d    = state_q;
      s_sel_d    = s_sel_q;
      s_addr_d   = s_addr_q;
      s_wdata_d  = s_wdata_q;
      s_rd_d     = s_rd_q;
      s_we_d     = s_we_q;
      cnt_d      = cnt_q;
      m_rdata_d  = m_rdata_q;
      m_ready_d  = 1'b0;
      m_err_d    = m_err_q;
      err_addr_d = err_addr_q;
      err_cnt_d  = err_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (req.rd | req.we) begin
               s_addr_d  = req.addr;
               s_wdata_d = req.wdata;
               if ((|hit_1h) && (req.rd ^ req.we)) begin
                  s_sel_d = hit_1h;
                  s_rd_d  = req.rd;
                  s_we_d  = req.we;
                  cnt_d   = '0;
                  state_d = ACCESS;
               end else begin
                  // Unmapped or illegal rd+we: answer with an error, touch no slave.
                  m_ready_d  = 1'b1;
                  m_err_d    = 1'b1;
                  m_rdata_d  = '0;
                  err_addr_d = req.addr;
                  if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                  state_d    = RESP;
               end
            end
         end
         ACCESS: begin
            if (rdy_sel) begin
               m_rdata_d = s_rd_q ? rdata_sel : '0;
               m_err_d   = 1'b0;
               m_ready_d = 1'b1;
               s_sel_d   = '0;
               s_rd_d    = 1'b0;
               s_we_d    = 1'b0;
               state_d   = RESP;
            end else if ((TIMEOUT != 0) && (cnt_q == CW'(TO_M1))) begin
               m_rdata_d  = '0;
               m_err_d    = 1'b1;
               m_ready_d  = 1'b1;
               s_sel_d    = '0;
               s_rd_d     = 1'b0;
               s_we_d     = 1'b0;
               err_addr_d = s_addr_q;
               if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
               state_d    = RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Datapath and response registers; every output comes straight from a flop.
   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         s_sel_q    <= '0;
         s_addr_q   <= '0;
         s_wdata_q  <= '0;
         s_rd_q     <= 1'b0;
         s_we_q     <= 1'b0;
         cnt_q      <= '0;
         m_rdata_q  <= '0;
         m_ready_q  <= 1'b0;
         m_err_q    <= 1'b0;
         err_addr_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         s_sel_q    <= s_sel_d;
         s_addr_q   <= s_addr_d;
         s_wdata_q  <= s_wdata_d;
         s_rd_q     <= s_rd_d;
         s_we_q     <= s_we_d;
         cnt_q      <= cnt_d;
         m_rdata_q  <= m_rdata_d;
         m_ready_q  <= m_ready_d;
         m_err_q    <= m_err_d;
         err_addr_q <= err_addr_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign bus.s_sel   = s_sel_q;
   assign bus.s_addr  = s_addr_q;
   assign bus.s_wdata = s_wdata_q;
   assign bus.s_rd    = s_rd_q;
   assign bus.s_we    = s_we_q;
   assign bus.m_rdata = m_rdata_q;
   assign bus.m_ready = m_ready_q;
   assign bus.m_err   = m_err_q;
   assign err_addr    = err_addr_q;
   assign err_cnt     = err_cnt_q;
endmodule

// File: tb/tb_bus_hub.sv
// tb_bus_hub: directed tests for bus_hub with four slaves.
// Slave 0 covers 0x0000_0xxx. Slave 1 covers 0x0000_1xxx and is always ready.
// Slave 2 covers 0x0000_2xxx and is ready after 3 select cycles.
// Slave 3 covers 0x0000_xxxx (overlapping slave 0) and is never ready unless rdy3 is set.
module tb_bus_hub;
   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam logic [N*AW-1:0] BASE = {32'h0000_0000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
   localparam logic [N*AW-1:0] MASK = {32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000};

   logic        clk = 1'b0;
   logic        RSTN = 1'b0;
   logic [AW-1:0] err_addr;
   logic [7:0]  err_cnt;
   logic        rdy3 = 1'b0;
   logic [1:0]  w2;
   int          errors = 0;
   int          checks = 0;

   bus_hub_if #(.N_SLAVE(N), .AW(AW), .DW(DW)) bus ();

   bus_hub #(.N_SLAVE(N), .AW(AW), .DW(DW), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT(15)) dut (
      .clk(clk), .RSTN(RSTN), .bus(bus), .err_addr(err_addr), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   // Slave 2 wait-state model: ready once it has been selected for 3 edges.
   always @(posedge clk or negedge RSTN) begin
      if (!RSTN)            w2 <= 2'd0;
      else if (bus.s_sel[2]) w2 <= (w2 == 2'd3) ? w2 : w2 + 2'd1;
      else                  w2 <= 2'd0;
   end

   assign bus.s_ready = {rdy3, (w2 == 2'd3), 1'b1, 1'b1};
   assign bus.s_rdata = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h0BAD_0000};

   task automatic idle_bus();
      bus.m_rd = 1'b0; bus.m_we = 1'b0; bus.m_addr = '0; bus.m_wdata = '0;
   endtask

   // Drive a request at a negedge; it is sampled at the next posedge (E0).
   task automatic issue(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rd, input logic we);
      @(negedge clk);
      bus.m_addr = a; bus.m_wdata = d; bus.m_rd = rd; bus.m_we = we;
      @(negedge clk);
      idle_bus();
   endtask

   task automatic test_reset();
      idle_bus();
      #1;
      checks++; if (bus.s_sel !== 4'b0) begin errors++; $display("FAIL reset_sel got=%b exp=0", bus.s_sel); end
      checks++; if (bus.m_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", bus.m_ready); end
      checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_errcnt got=%0d exp=0", err_cnt); end
      checks++; if (bus.s_addr !== 32'h0 || bus.m_rdata !== 32'h0 || bus.s_rd !== 1'b0 || bus.s_we !== 1'b0)
         begin errors++; $display("FAIL reset_outs addr=%h rdata=%h rd=%b we=%b exp all 0", bus.s_addr, bus.m_rdata, bus.s_rd, bus.s_we); end
      repeat (2) @(negedge clk);
      RSTN = 1'b1;
   endtask

   task automatic test_zero_wait_read();
      issue(32'h1004, 32'h0, 1'b1, 1'b0);
      checks++; if (bus.s_sel !== 4'b0010 || bus.s_rd !== 1'b1 || bus.s_addr !== 32'h1004)
         begin errors++; $display("FAIL zw_access sel=%b rd=%b addr=%h exp 0010/1/1004", bus.s_sel, bus.s_rd, bus.s_addr); end
      checks++; if (bus.m_ready !== 1'b0) begin errors++; $display("FAIL zw_early_ready got=%b exp=0", bus.m_ready); end
      @(negedge clk);
      checks++; if (bus.m_ready !== 1'b1 || bus.m_err !== 1'b0) begin errors++; $display("FAIL zw_ready ready=%b err=%b exp 1/0", bus.m_ready, bus.m_err); end
      checks++; if (bus.m_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL zw_rdata got=%h exp=deadbeef", bus.m_rdata); end
      checks++; if (bus.s_sel !== 4'b0 || bus.s_rd !== 1'b0) begin errors++; $display("FAIL zw_strobe_drop sel=%b rd=%b exp 0/0", bus.s_sel, bus.s_rd); end
      @(negedge clk);
      checks++; if (bus.m_ready !== 1'b0) begin errors++; $display("FAIL zw_pulse got=%b exp=0", bus.m_ready); end
   endtask

   task automatic test_wait_write();
      issue(32'h2008, 32'h1234_5678, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         if (i != 0) @(negedge clk);
         checks++; if (bus.s_we !== 1'b1 || bus.s_sel !== 4'b0100 || bus.s_wdata !== 32'h1234_5678 || bus.m_ready !== 1'b0)
            begin errors++; $display("FAIL ww_access%0d we=%b sel=%b wdata=%h ready=%b exp 1/0100/12345678/0", i, bus.s_we, bus.s_sel, bus.s_wdata, bus.m_ready); end
      end
      @(negedge clk);
      checks++; if (bus.m_ready !== 1'b1 || bus.m_err !== 1'b0 || bus.m_rdata !== 32'h0)
         begin errors++; $display("FAIL ww_resp ready=%b err=%b rdata=%h exp 1/0/0", bus.m_ready, bus.m_err, bus.m_rdata); end
      checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL ww_errcnt got=%0d exp=0", err_cnt); end
      @(negedge clk);
   endtask

   task automatic test_unmapped();
      issue(32'hFFFF_0000, 32'h0, 1'b1, 1'b0);
      checks++; if (bus.s_sel !== 4'b0 || bus.s_rd !== 1'b0) begin errors++; $display("FAIL um_nosel sel=%b rd=%b exp 0/0", bus.s_sel, bus.s_rd); end
      checks++; if (bus.m_ready !== 1'b1 || bus.m_err !== 1'b1 || bus.m_rdata !== 32'h0)
         begin errors++; $display("FAIL um_resp ready=%b err=%b rdata=%h exp 1/1/0", bus.m_ready, bus.m_err, bus.m_rdata); end
      checks++; if (err_addr !== 32'hFFFF_0000 || err_cnt !== 8'd1)
         begin errors++; $display("FAIL um_errlog addr=%h cnt=%0d exp ffff0000/1", err_addr, err_cnt); end
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int strobes = 0;
      bit done = 0;
      issue(32'h3000, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 40 && !done; i++) begin
         if (bus.m_ready) done = 1;
         else begin
            if (bus.s_rd && bus.s_sel == 4'b1000) strobes++;
            @(negedge clk);
         end
      end
      checks++; if (!done) begin errors++; $display("FAIL to_no_ready got no m_ready within 40 cycles"); end
      checks++; if (strobes != 15) begin errors++; $display("FAIL to_strobe_cycles got=%0d exp=15", strobes); end
      checks++; if (bus.m_err !== 1'b1 || bus.s_rd !== 1'b0 || err_cnt !== 8'd2 || err_addr !== 32'h3000)
         begin errors++; $display("FAIL to_resp err=%b rd=%b cnt=%0d addr=%h exp 1/0/2/3000", bus.m_err, bus.s_rd, err_cnt, err_addr); end
      @(negedge clk);
   endtask

   task automatic test_overlap_illegal();
      issue(32'h0000_0004, 32'h0, 1'b1, 1'b0);
      checks++; if (bus.s_sel !== 4'b0001) begin errors++; $display("FAIL ov_sel got=%b exp=0001", bus.s_sel); end
      @(negedge clk);
      checks++; if (bus.m_ready !== 1'b1 || bus.m_rdata !== 32'h0BAD_0000)
         begin errors++; $display("FAIL ov_rdata ready=%b rdata=%h exp 1/0bad0000", bus.m_ready, bus.m_rdata); end
      @(negedge clk);
      issue(32'h1004, 32'h55, 1'b1, 1'b1);
      checks++; if (bus.s_sel !== 4'b0 || bus.s_rd !== 1'b0 || bus.s_we !== 1'b0)
         begin errors++; $display("FAIL il_nostrobe sel=%b rd=%b we=%b exp 0/0/0", bus.s_sel, bus.s_rd, bus.s_we); end
      checks++; if (bus.m_ready !== 1'b1 || bus.m_err !== 1'b1 || err_cnt !== 8'd3)
         begin errors++; $display("FAIL il_resp ready=%b err=%b cnt=%0d exp 1/1/3", bus.m_ready, bus.m_err, err_cnt); end
      @(negedge clk);
      // A held unmapped request retries every 2 cycles: 300 cycles give 150 more errors.
      bus.m_addr = 32'hFFFF_0010; bus.m_rd = 1'b1;
      repeat (300) @(negedge clk);
      checks++; if (err_cnt !== 8'd153) begin errors++; $display("FAIL sat_mid got=%0d exp=153", err_cnt); end
      repeat (300) @(negedge clk);
      idle_bus();
      repeat (2) @(negedge clk);
      checks++; if (err_cnt !== 8'd255 || err_addr !== 32'hFFFF_0010)
         begin errors++; $display("FAIL sat_cnt cnt=%0d addr=%h exp 255/ffff0010", err_cnt, err_addr); end
   endtask

   task automatic test_back_to_back();
      logic [8:0] exp_pat = 9'b010_010_010;
      @(negedge clk);
      bus.m_addr = 32'h1010; bus.m_rd = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         checks++; if (bus.m_ready !== exp_pat[8-i]) begin errors++; $display("FAIL b2b_cyc%0d ready=%b exp=%b", i, bus.m_ready, exp_pat[8-i]); end
      end
      idle_bus();
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid_access();
      issue(32'h3004, 32'h0, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      checks++; if (bus.s_rd !== 1'b1 || bus.s_sel !== 4'b1000) begin errors++; $display("FAIL rm_pre rd=%b sel=%b exp 1/1000", bus.s_rd, bus.s_sel); end
      RSTN = 1'b0;
      #1;
      checks++; if (bus.s_sel !== 4'b0 || bus.s_rd !== 1'b0 || bus.s_we !== 1'b0 || bus.m_ready !== 1'b0 || err_cnt !== 8'd0 || err_addr !== 32'h0)
         begin errors++; $display("FAIL rm_async sel=%b rd=%b we=%b ready=%b cnt=%0d eaddr=%h exp all 0", bus.s_sel, bus.s_rd, bus.s_we, bus.m_ready, err_cnt, err_addr); end
      @(negedge clk);
      RSTN = 1'b1;
      issue(32'h1008, 32'h0, 1'b1, 1'b0);
      @(negedge clk);
      checks++; if (bus.m_ready !== 1'b1 || bus.m_err !== 1'b0 || bus.m_rdata !== 32'hDEAD_BEEF)
         begin errors++; $display("FAIL rm_after ready=%b err=%b rdata=%h exp 1/0/deadbeef", bus.m_ready, bus.m_err, bus.m_rdata); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_zero_wait_read();
      test_wait_write();
      test_unmapped();
      test_timeout();
      test_overlap_illegal();
      test_back_to_back();
      test_reset_mid_access();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Absolute guard so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog expired before test sequence completed");
      $fatal(1);
   end
endmodule

// File: doc/bus_hub.md
# bus_hub

Parametrised bus controller between the pipelined CPU data port and N memory-mapped slaves (SRAM, VGA text/graph/regs, cursor, SEG, …). It decodes addresses against per-slave base/mask pairs, drives a one-hot slave select, and waits on each slave's ready so slaves may insert wait states. It also aborts stuck accesses on timeout and returns an error response with a captured fault address.

## Interface
- N_SLAVE, 8: number of slave channels (1–16).
- AW, 32: address width.
- DW, 32: data width.
- SLAVE_BASE, 0: N_SLAVE×AW flattened base addresses; slave i at bits [i*AW +: AW].
- SLAVE_MASK, 0: N_SLAVE×AW flattened masks; slave i matches when (addr & mask_i) == base_i.
- TIMEOUT, 15: maximum wait cycles in ACCESS; 0 disables timeout.
- clk  in  1  system clock, rising-edge.
- RSTN  in  1  asynchronous active-low reset.
- m_addr  in  AW  master address.
- m_wdata  in  DW  master write data.
- m_rd  in  1  read request (level).
- m_we  in  1  write request (level).
- m_rdata  out  DW  read data, valid while m_ready=1.
- m_ready  out  1  one-cycle completion pulse.
- m_err  out  1  error flag, valid with m_ready.
- s_sel  out  N_SLAVE  one-hot slave select.
- s_addr  out  AW  latched address to all slaves.
- s_wdata  out  DW  latched write data to all slaves.
- s_rd  out  1  slave read strobe, qualified by s_sel.
- s_we  out  1  slave write strobe, qualified by s_sel.
- s_rdata  in  N_SLAVE×DW  per-slave read data, flattened.
- s_ready  in  N_SLAVE  per-slave ready.
- err_addr  out  AW  address of the most recent error.
- err_cnt  out  8  saturating error count.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: when m_rd|m_we is 1 at a clock edge, latch m_addr, m_wdata and op into s_addr/s_wdata/op, then decode.
  - Decode uses the lowest-index matching slave (priority on overlap).
  - Match and exactly one of rd/we set: set s_sel one-hot, s_rd/s_we per op, clear wait counter, go to ACCESS.
  - No match, or m_rd&m_we both set: no slave strobe; go to RESP with error.
- ACCESS: s_sel, s_rd, s_we, s_addr and s_wdata are held stable.
  - s_ready[sel]=1 at an edge: capture s_rdata[sel] (read only; a write yields m_rdata=0); clear s_sel, s_rd, s_we; go to RESP with no error.
  - Otherwise increment the wait counter. When the counter equals TIMEOUT (TIMEOUT≠0): clear strobes, go to RESP with error.
  - s_ready of non-selected slaves is ignored.
- RESP: m_ready=1 for exactly one cycle. m_err and m_rdata are held from the decision; m_rdata=0 on error. Next state is always IDLE.
- Error bookkeeping: on every transition into RESP with error, err_addr takes the latched address and err_cnt increments, saturating at 255.
- The master must drop or change its request in the cycle m_ready=1. A request still asserted in IDLE starts a new transaction.
- Reset (async, any state, including mid-ACCESS): state goes to IDLE and all outputs go to 0 (m_rdata, m_ready, m_err, s_sel, s_addr, s_wdata, s_rd, s_we, err_addr, err_cnt). The slave access in progress is abandoned.

## Timing
- Request sampled at edge E0. With s_ready=1 already in the first ACCESS cycle, m_ready is high in the cycle after E1. Zero-wait latency is 2 cycles from request to m_ready.
- Each slave wait cycle adds 1 cycle.
- A decode error reaches m_ready 1 cycle after the request edge.
- A timeout reaches m_ready TIMEOUT+1 cycles after entering ACCESS.
- Back-to-back transactions: at most one transaction every 3 cycles (IDLE, ACCESS, RESP). IDLE is always visited for one cycle.
- All outputs are registered; there are no combinational paths from slave inputs to master outputs.

## Test plan
- Zero-wait read: N_SLAVE=4, slave 1 base 0x0000_1000 mask 0xFFFF_F000, read 0x1004 with s_rdata1=0xDEADBEEF and s_ready1 tied 1 -> s_sel=0010 with s_rd=1 for 1 cycle; m_ready pulses 2 cycles after request with m_rdata=0xDEADBEEF, m_err=0.
- Wait-state write: slave 2 raises ready after 3 cycles; write 0x12345678 -> s_we and s_wdata stable for 4 ACCESS cycles; m_ready at cycle 5 with m_err=0; err_cnt unchanged.
- Unmapped address 0xFFFF_0000 -> no s_sel bit set; m_ready 1 cycle later with m_err=1, m_rdata=0; err_addr=0xFFFF_0000; err_cnt=1.
- Timeout: TIMEOUT=15, selected slave never ready -> strobes drop after 15 ACCESS cycles; m_err=1; err_cnt increments.
- Overlap and illegal op: slaves 0 and 3 both match 0x0 -> only s_sel[0] asserted. m_rd&m_we both set -> m_err=1 with no strobes. 300 errors -> err_cnt=255.
- Reset mid-ACCESS: drop RSTN during a wait -> s_sel=0, s_rd=s_we=0, m_ready=0, err_cnt=0 immediately with no clock edge; after release, a new read completes normally.
